// File: rtl/nrs_index_seq_gen.sv
// NB-IoT NRS subcarrier index stream generator: iterative N_cell_ID mod 6, then
// one (6m + v + v_shift) mod 12 index per valid/ready beat over all (port, symb, m).
module nrs_index_seq_gen #(
  parameter int CELL_ID_W = 9,
  parameter int NUM_SYMB  = 2,
  parameter int MAX_PORTS = 2,
  parameter int IDX_W     = 4,
  localparam int SYMB_W   = (NUM_SYMB > 1) ? $clog2(NUM_SYMB) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CELL_ID_W-1:0] N_cell_ID,
  input  logic                 two_ports,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [IDX_W-1:0]     index_demap,
  output logic                 out_port,
  output logic [SYMB_W-1:0]    out_symb,
  output logic                 out_m,
  output logic                 out_last,
  output logic [2:0]           v_shift,
  output logic                 busy,
  output logic                 done
);

  localparam int MOD_STEPS = CELL_ID_W - 2;
  localparam int K_W       = (MOD_STEPS > 1) ? $clog2(MOD_STEPS) : 1;

  typedef enum logic [1:0] {IDLE, MOD, EMIT, DONE} state_t;

  state_t                state, state_nxt;
  logic [CELL_ID_W-1:0]  r, sub, r_nxt;
  logic [K_W-1:0]        k;
  logic                  tp;
  logic                  m, port;
  logic [SYMB_W-1:0]     symb;
  logic                  last_beat;
  logic [2:0]            v;
  logic [4:0]            veq, idx5;

  // Restoring-division style step: 6<<k still fits in CELL_ID_W bits for k <= CELL_ID_W-3.
  assign sub   = CELL_ID_W'(6) << k;
  assign r_nxt = (r >= sub) ? (r - sub) : r;

  assign last_beat = m && (symb == SYMB_W'(NUM_SYMB - 1)) && (port == tp);

  // Port 1 swaps the even/odd symbol offsets, so the offset is 3 when exactly one of them is odd.
  assign v    = (symb[0] ^ port) ? 3'd3 : 3'd0;
  assign veq  = (m ? 5'd6 : 5'd0) + {2'b00, v} + {2'b00, v_shift};
  assign idx5 = (veq > 5'd11) ? (veq - 5'd12) : veq;

  assign index_demap = IDX_W'(idx5);
  assign out_port    = port;
  assign out_symb    = symb;
  assign out_m       = m;
  assign out_valid   = (state == EMIT);
  assign out_last    = (state == EMIT) && last_beat;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = MOD;
      MOD:  if (k == '0) state_nxt = EMIT;
      EMIT: if (out_ready && last_beat) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r       <= '0;
      k       <= '0;
      tp      <= 1'b0;
      m       <= 1'b0;
      symb    <= '0;
      port    <= 1'b0;
      v_shift <= 3'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          r    <= N_cell_ID;
          tp   <= two_ports && (MAX_PORTS > 1);
          k    <= K_W'(MOD_STEPS - 1);
          m    <= 1'b0;
          symb <= '0;
          port <= 1'b0;
        end
        MOD: begin
          r <= r_nxt;
          if (k == '0) v_shift <= r_nxt[2:0];
          else         k <= k - K_W'(1);
        end
        EMIT: if (out_ready) begin
          // Counters return to zero after the final beat rather than wrapping past it.
          if (last_beat) begin
            m    <= 1'b0;
            symb <= '0;
            port <= 1'b0;
          end else if (!m) begin
            m <= 1'b1;
          end else begin
            m <= 1'b0;
            if (symb == SYMB_W'(NUM_SYMB - 1)) begin
              symb <= '0;
              port <= 1'b1;
            end else begin
              symb <= symb + SYMB_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nrs_index_seq_gen.sv
// Bench for nrs_index_seq_gen: fixed vector table, reset abort, and a randomized
// backpressure sweep over all cell IDs checked against a beat-list model.
module tb_nrs_index_seq_gen;
  localparam int CW = 9, NS = 2, MP = 2, IW = 4, MS = CW - 2;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  logic          clk = 1'b0;
  logic          rst, start, two_ports, out_ready;
  logic [CW-1:0] N_cell_ID;
  logic          out_valid, out_port, out_m, out_last, busy, done;
  logic [IW-1:0] index_demap;
  logic [SW-1:0] out_symb;
  logic [2:0]    v_shift;

  nrs_index_seq_gen #(.CELL_ID_W(CW), .NUM_SYMB(NS), .MAX_PORTS(MP), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .N_cell_ID(N_cell_ID), .two_ports(two_ports),
    .out_ready(out_ready), .out_valid(out_valid), .index_demap(index_demap),
    .out_port(out_port), .out_symb(out_symb), .out_m(out_m), .out_last(out_last),
    .v_shift(v_shift), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {int idx; int port; int symb; int m; bit last;} beat_t;
  typedef struct {int cid; bit tp; int vs; int i0; int i1; int i2; int i3;} vec_t;

  beat_t exp_q[$];
  int    got_idx[$];

  // Model: enumerate (port, symb, m) in stream order straight from the index formula.
  function automatic void build(input int cid, input bit tp);
    beat_t b;
    exp_q.delete();
    for (int p = 0; p < (tp ? 2 : 1); p++)
      for (int s = 0; s < NS; s++)
        for (int mm = 0; mm < 2; mm++) begin
          b.idx  = (6 * mm + (3 * (s % 2) + 3 * p) % 6 + cid % 6) % 12;
          b.port = p; b.symb = s; b.m = mm; b.last = 1'b0;
          exp_q.push_back(b);
        end
    b = exp_q[exp_q.size() - 1];
    b.last = 1'b1;
    exp_q[exp_q.size() - 1] = b;
  endfunction

  task automatic run_pass(input int cid, input bit tp, input int rdy_pct, input bit inj);
    int    lat, cyc;
    bit    held;
    int    h_idx, h_port, h_symb, h_m, h_last;
    beat_t b;
    build(cid, tp);
    got_idx.delete();
    @(negedge clk);
    start = 1'b1; N_cell_ID = CW'(cid); two_ports = tp; out_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!out_valid && lat < 50);
    chk("latency", lat, MS + 1);
    chk("v_shift", v_shift, cid % 6);
    cyc = 0; held = 1'b0;
    h_idx = 0; h_port = 0; h_symb = 0; h_m = 0; h_last = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      chk("valid_held_high", out_valid, 1);
      chk("v_shift_stable", v_shift, cid % 6);
      if (held) begin
        chk("stall_idx", index_demap, h_idx);
        chk("stall_port", out_port, h_port);
        chk("stall_symb", out_symb, h_symb);
        chk("stall_m", out_m, h_m);
        chk("stall_last", out_last, h_last);
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      start     = inj && ($urandom_range(9) == 0);
      N_cell_ID = CW'($urandom_range(503));
      two_ports = $urandom_range(1);
      if (out_valid && out_ready) begin
        b = exp_q.pop_front();
        chk("beat_idx", index_demap, b.idx);
        chk("beat_port", out_port, b.port);
        chk("beat_symb", out_symb, b.symb);
        chk("beat_m", out_m, b.m);
        chk("beat_last", out_last, b.last);
        got_idx.push_back(int'(index_demap));
        held = 1'b0;
      end else if (out_valid) begin
        held = 1'b1;
        h_idx = index_demap; h_port = out_port; h_symb = out_symb; h_m = out_m; h_last = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) chk("beat_timeout", 0, 1);
    start = 1'b0; out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_no_valid", out_valid, 0);
    chk("done_busy", busy, 1);
    @(negedge clk);
    chk("done_once", done, 0);
    chk("idle_not_busy", busy, 0);
  endtask

  vec_t tbl[6];

  initial begin
    int cnt;
    tbl[0] = '{503, 1'b0, 5, 5, 11, 8, 2};
    tbl[1] = '{503, 1'b1, 5, 5, 11, 8, 2};
    tbl[2] = '{0,   1'b0, 0, 0, 6, 3, 9};
    tbl[3] = '{6,   1'b0, 0, 0, 6, 3, 9};
    tbl[4] = '{7,   1'b1, 1, 1, 7, 4, 10};
    tbl[5] = '{255, 1'b0, 3, 3, 9, 6, 0};

    rst = 1'b1; start = 1'b0; two_ports = 1'b0; out_ready = 1'b0; N_cell_ID = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vshift", v_shift, 0);
    chk("rst_idx", index_demap, 0);
    chk("rst_last", out_last, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_pass(tbl[i].cid, tbl[i].tp, 100, 1'b0);
      chk("tbl_beats", got_idx.size(), tbl[i].tp ? 8 : 4);
      if (got_idx.size() >= 4) begin
        chk("tbl_i0", got_idx[0], tbl[i].i0);
        chk("tbl_i1", got_idx[1], tbl[i].i1);
        chk("tbl_i2", got_idx[2], tbl[i].i2);
        chk("tbl_i3", got_idx[3], tbl[i].i3);
      end
      if (tbl[i].tp && got_idx.size() == 8) begin
        chk("tbl_p1_i0", got_idx[4], tbl[i].i2);
        chk("tbl_p1_i1", got_idx[5], tbl[i].i3);
        chk("tbl_p1_i2", got_idx[6], tbl[i].i0);
        chk("tbl_p1_i3", got_idx[7], tbl[i].i1);
      end
      chk("tbl_vshift_kept", v_shift, tbl[i].vs);
    end

    // Reset in the middle of a pass aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; N_cell_ID = CW'(503); two_ports = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 50) begin @(negedge clk); cnt++; end
    chk("rst_test_reached_emit", out_valid, 1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_vshift", v_shift, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || out_valid) cnt++;
    end
    chk("no_activity_after_rst", cnt, 0);
    out_ready = 1'b0;

    // Sweep every cell ID with random backpressure and start pulses while busy.
    for (int cid = 0; cid <= 503; cid++)
      run_pass(cid, 1'($urandom_range(1)), 30 + $urandom_range(70), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
